// File: rtl/morse_lcd_driver.sv
`default_nettype none
// ============================================================================
// morse_lcd_driver : HD44780 8-bit init + two-line refresh from snapshotted text
// Option macro LCD_CHANGE_ONLY_EN : refresh only when the input text changes.
// Revision : 1.0
// ============================================================================
module morse_lcd_driver #(
  parameter int unsigned PWR_WAIT_CYC   = 750000,
  parameter int unsigned E_HIGH_CYC     = 12,
  parameter int unsigned WAIT_CYC       = 2000,
  parameter int unsigned CLEAR_WAIT_CYC = 80000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [127:0] lcd_line1,
  input  logic [127:0] lcd_line2,
  output logic         lcd_e,
  output logic         lcd_rs,
  output logic         lcd_rw,
  output logic [7:0]   lcd_data,
  output logic         init_done,
  output logic         frame_done
);

  typedef enum logic [2:0] {
    S_PWR_WAIT = 3'd0,
    S_INIT     = 3'd1,
    S_SNAP     = 3'd2,
    S_ADDR1    = 3'd3,
    S_LINE1    = 3'd4,
    S_ADDR2    = 3'd5,
    S_LINE2    = 3'd6,
    S_IDLE     = 3'd7
  } state_t;

  typedef enum logic [1:0] {
    P_SETUP = 2'd0,
    P_EHIGH = 2'd1,
    P_WAIT  = 2'd2
  } phase_t;

  localparam logic [7:0] C_CMD_LINE1 = 8'h80;
  localparam logic [7:0] C_CMD_LINE2 = 8'hC0;
  localparam logic [7:0] C_BLANK     = 8'h20;

  state_t         r_state, w_state_nxt;
  phase_t         r_phase, w_phase_nxt;
  logic [31:0]    r_cnt, w_cnt_nxt;
  logic [3:0]     r_idx, w_idx_nxt;
  logic [1:0]     r_init_idx, w_init_idx_nxt;
  logic           r_init_done, w_init_done_nxt;
  logic [127:0]   r_snap1, r_snap2;

  logic           w_writing;
  logic           w_write_done;
  logic [31:0]    w_wait_len;
  logic [6:0]     w_bitpos;
  logic [7:0]     w_char_raw;
  logic [7:0]     w_char;
  logic [7:0]     w_init_cmd;

  assign w_writing = (r_state == S_INIT)  || (r_state == S_ADDR1) ||
                     (r_state == S_LINE1) || (r_state == S_ADDR2) ||
                     (r_state == S_LINE2);

  // The clear command needs a much longer settle time than every other write.
  assign w_wait_len = ((r_state == S_INIT) && (r_init_idx == 2'd3)) ? CLEAR_WAIT_CYC : WAIT_CYC;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_PWR_WAIT;
      r_phase     <= P_SETUP;
      r_cnt       <= '0;
      r_idx       <= '0;
      r_init_idx  <= '0;
      r_init_done <= 1'b0;
      r_snap1     <= '0;
      r_snap2     <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_phase     <= w_phase_nxt;
      r_cnt       <= w_cnt_nxt;
      r_idx       <= w_idx_nxt;
      r_init_idx  <= w_init_idx_nxt;
      r_init_done <= w_init_done_nxt;
      if (r_state == S_SNAP) begin
        r_snap1 <= lcd_line1;
        r_snap2 <= lcd_line2;
      end
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_phase_nxt     = r_phase;
    w_cnt_nxt       = r_cnt;
    w_idx_nxt       = r_idx;
    w_init_idx_nxt  = r_init_idx;
    w_init_done_nxt = r_init_done;
    w_write_done    = 1'b0;

    if (w_writing) begin
      case (r_phase)
        P_SETUP: begin
          w_phase_nxt = P_EHIGH;
          w_cnt_nxt   = '0;
        end
        P_EHIGH: begin
          if (r_cnt == E_HIGH_CYC - 32'd1) begin
            w_phase_nxt = P_WAIT;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + 32'd1;
          end
        end
        P_WAIT: begin
          if (r_cnt == w_wait_len - 32'd1) begin
            w_write_done = 1'b1;
            w_phase_nxt  = P_SETUP;
            w_cnt_nxt    = '0;
          end else begin
            w_cnt_nxt = r_cnt + 32'd1;
          end
        end
        default: begin
          w_phase_nxt = P_SETUP;
          w_cnt_nxt   = '0;
        end
      endcase
    end

    case (r_state)
      S_PWR_WAIT: begin
        if (r_cnt == PWR_WAIT_CYC - 32'd1) begin
          w_state_nxt = S_INIT;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 32'd1;
        end
      end
      S_INIT: begin
        if (w_write_done) begin
          if (r_init_idx == 2'd3) begin
            w_state_nxt     = S_SNAP;
            w_init_done_nxt = 1'b1;
            w_init_idx_nxt  = '0;
          end else begin
            w_init_idx_nxt = r_init_idx + 2'd1;
          end
        end
      end
      S_SNAP:  w_state_nxt = S_ADDR1;
      S_ADDR1: if (w_write_done) w_state_nxt = S_LINE1;
      S_LINE1: begin
        if (w_write_done) begin
          w_idx_nxt = r_idx + 4'd1;
          if (r_idx == 4'd15) w_state_nxt = S_ADDR2;
        end
      end
      S_ADDR2: if (w_write_done) w_state_nxt = S_LINE2;
      S_LINE2: begin
        if (w_write_done) begin
          w_idx_nxt = r_idx + 4'd1;
          if (r_idx == 4'd15) w_state_nxt = S_IDLE;
        end
      end
      S_IDLE: begin
`ifdef LCD_CHANGE_ONLY_EN
        if ({lcd_line1, lcd_line2} != {r_snap1, r_snap2}) w_state_nxt = S_SNAP;
`else
        w_state_nxt = S_SNAP;
`endif
      end
      default: w_state_nxt = S_PWR_WAIT;
    endcase
  end

  // Char 0 sits in the top byte, so the bit offset is (15 - idx) * 8.
  assign w_bitpos   = {~r_idx, 3'b000};
  assign w_char_raw = (r_state == S_LINE2) ? r_snap2[w_bitpos +: 8] : r_snap1[w_bitpos +: 8];
  assign w_char     = ((w_char_raw >= 8'h20) && (w_char_raw <= 8'h7E)) ? w_char_raw : C_BLANK;

  always_comb begin
    w_init_cmd = 8'h38;
    case (r_init_idx)
      2'd0: w_init_cmd = 8'h38;
      2'd1: w_init_cmd = 8'h0C;
      2'd2: w_init_cmd = 8'h06;
      2'd3: w_init_cmd = 8'h01;
      default: w_init_cmd = 8'h38;
    endcase
  end

  always_comb begin
    lcd_data = 8'h00;
    case (r_state)
      S_INIT:  lcd_data = w_init_cmd;
      S_ADDR1: lcd_data = C_CMD_LINE1;
      S_LINE1: lcd_data = w_char;
      S_ADDR2: lcd_data = C_CMD_LINE2;
      S_LINE2: lcd_data = w_char;
      default: lcd_data = 8'h00;
    endcase
  end

  assign lcd_e      = w_writing && (r_phase == P_EHIGH);
  assign lcd_rs     = (r_state == S_LINE1) || (r_state == S_LINE2);
  assign lcd_rw     = 1'b0;
  assign init_done  = r_init_done;
  assign frame_done = (r_state == S_LINE2) && (r_idx == 4'd15) && w_write_done;

endmodule
`default_nettype wire

// File: tb/tb_morse_lcd_driver.sv
`default_nettype none
// tb_morse_lcd_driver : directed stimulus checked against a cycle-level model of the LCD bus
// plus literal expectations on write order and timing.
module tb_morse_lcd_driver;

  localparam int PW = 10;
  localparam int EH = 2;
  localparam int WT = 4;
  localparam int CW = 8;
  localparam logic [31:0] INIT_CMDS = 32'h380C0601;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [127:0] line1, line2;
  logic         lcd_e, lcd_rs, lcd_rw, init_done, frame_done;
  logic [7:0]   lcd_data;

  int n_chk = 0;
  int n_err = 0;

  morse_lcd_driver #(
    .PWR_WAIT_CYC(PW), .E_HIGH_CYC(EH), .WAIT_CYC(WT), .CLEAR_WAIT_CYC(CW)
  ) dut (
    .clk(clk), .rst(rst), .lcd_line1(line1), .lcd_line2(line2),
    .lcd_e(lcd_e), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_data(lcd_data),
    .init_done(init_done), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  function automatic logic [127:0] s2v(input string s);
    logic [127:0] v;
    v = '0;
    for (int i = 0; i < 16; i++) v[127-8*i -: 8] = s[i];
    return v;
  endfunction

  function automatic logic [7:0] san(input logic [7:0] b);
    return (b >= 8'h20 && b <= 8'h7E) ? b : 8'h20;
  endfunction

  // ---------------- behavioural model ----------------
  logic         exp_e = 0, exp_rs = 0, exp_init = 0, exp_fd = 0;
  logic [7:0]   exp_d = 0;
  logic         m_init = 0, m_abort = 0, m_valid = 0;
  logic [127:0] smp1, smp2, snap1, snap2;

  task automatic mstep(input logic e, input logic rs, input logic [7:0] d, input logic fd);
    logic r;
    @(posedge clk);
    smp1 = line1;
    smp2 = line2;
    r    = rst;
    #1;
    if (r) begin
      m_abort = 1; m_init = 0;
      exp_e = 0; exp_rs = 0; exp_d = 8'h00; exp_init = 0; exp_fd = 0;
    end else begin
      exp_e = e; exp_rs = rs; exp_d = d; exp_init = m_init; exp_fd = fd;
    end
  endtask

  task automatic mwrite(input logic rs, input logic [7:0] d, input int wlen, input bit cap, input bit last);
    mstep(0, rs, d, 0);
    if (m_abort) return;
    if (cap) begin snap1 = smp1; snap2 = smp2; end
    for (int i = 0; i < EH; i++) begin mstep(1, rs, d, 0); if (m_abort) return; end
    for (int i = 0; i < wlen; i++) begin
      mstep(0, rs, d, last && (i == wlen - 1));
      if (m_abort) return;
    end
  endtask

  task automatic mframe();
    mwrite(0, 8'h80, WT, 1, 0);
    if (m_abort) return;
    for (int i = 0; i < 16; i++) begin
      mwrite(1, san(snap1[127-8*i -: 8]), WT, 0, 0);
      if (m_abort) return;
    end
    mwrite(0, 8'hC0, WT, 0, 0);
    if (m_abort) return;
    for (int i = 0; i < 16; i++) begin
      mwrite(1, san(snap2[127-8*i -: 8]), WT, 0, i == 15);
      if (m_abort) return;
    end
  endtask

  task automatic run_seq();
    for (int i = 0; i < PW - 1; i++) begin mstep(0, 0, 8'h00, 0); if (m_abort) return; end
    for (int i = 0; i < 4; i++) begin
      mwrite(0, INIT_CMDS[31-8*i -: 8], (i == 3) ? CW : WT, 0, 0);
      if (m_abort) return;
    end
    m_init = 1;
    mstep(0, 0, 8'h00, 0);
    if (m_abort) return;
    forever begin
      mframe();
      if (m_abort) return;
      mstep(0, 0, 8'h00, 0);
      if (m_abort) return;
      mstep(0, 0, 8'h00, 0);
      if (m_abort) return;
`ifdef LCD_CHANGE_ONLY_EN
      while (smp1 == snap1 && smp2 == snap2) begin
        mstep(0, 0, 8'h00, 0);
        if (m_abort) return;
      end
`endif
    end
  endtask

  initial begin
    while (!m_abort) mstep(0, 0, 8'h00, 0);
    m_valid = 1;
    forever begin
      m_abort = 0;
      run_seq();
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      n_chk++;
      if ({lcd_e, lcd_rs, lcd_rw, lcd_data, init_done, frame_done} !==
          {exp_e, exp_rs, 1'b0, exp_d, exp_init, exp_fd}) begin
        n_err++;
        $display("FAIL model t=%0t: got e=%b rs=%b rw=%b d=%h init=%b fd=%b, want e=%b rs=%b rw=0 d=%h init=%b fd=%b",
                 $time, lcd_e, lcd_rs, lcd_rw, lcd_data, init_done, frame_done,
                 exp_e, exp_rs, exp_d, exp_init, exp_fd);
      end
    end
  end

  // ---------------- bus monitor ----------------
  int         cyc = 0;
  logic [8:0] wq[$];
  int         n_fd = 0, fd_cyc = 0, init_cyc = 0, erun = 0, erun_bad = 0;
  logic       prev_e = 0, prev_init = 0;

  always @(posedge clk) cyc <= rst ? 1 : cyc + 1;

  always @(negedge clk) begin
    if (lcd_e === 1'b1 && prev_e !== 1'b1) wq.push_back({lcd_rs, lcd_data});
    if (lcd_e === 1'b1) erun++;
    else if (erun != 0) begin
      if (erun != EH) erun_bad++;
      erun = 0;
    end
    if (init_done === 1'b1 && prev_init !== 1'b1) init_cyc = cyc;
    if (frame_done === 1'b1) begin n_fd++; fd_cyc = cyc; end
    prev_e    = lcd_e;
    prev_init = init_done;
  end

  function automatic logic [8:0] wr(input int i);
    if (i < wq.size()) return wq[i];
    return 9'h1FF;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", nm, got, want);
    end
  endtask

  task automatic wait_fd(input int n, input int budget, input string nm);
    int k = 0;
    while (n_fd < n && k < budget) begin tick(); k++; end
    n_chk++;
    if (n_fd < n) begin
      n_err++;
      $display("FAIL %s: timeout, frame_done count %0d want %0d", nm, n_fd, n);
    end
  endtask

  task automatic wait_writes(input int n, input int budget, input string nm);
    int k = 0;
    while (wq.size() < n && k < budget) begin tick(); k++; end
    n_chk++;
    if (wq.size() < n) begin
      n_err++;
      $display("FAIL %s: timeout, writes %0d want %0d", nm, wq.size(), n);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", n_err + 1, n_chk + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- directed stimulus ----------------
  initial begin
    rst   = 1'b1;
    line1 = s2v(">> ENCODE       ");
    line2 = s2v("   DECODE       ");
    repeat (3) tick();
    chk("rst_e",    32'(lcd_e),      32'h0);
    chk("rst_data", 32'(lcd_data),   32'h0);
    chk("rst_init", 32'(init_done),  32'h0);
    chk("rst_fd",   32'(frame_done), 32'h0);
    rst = 1'b0;

    wait_fd(1, 400, "frame1");
    chk("init_rise_cyc", 32'(init_cyc), 32'd43);
    chk("fd1_cyc",       32'(fd_cyc),   32'd281);
    chk("f1_nwrites",    32'(wq.size()), 32'd38);
    chk("w0_38", 32'(wr(0)), 32'h038);
    chk("w1_0C", 32'(wr(1)), 32'h00C);
    chk("w2_06", 32'(wr(2)), 32'h006);
    chk("w3_01", 32'(wr(3)), 32'h001);
    chk("f1_addr1", 32'(wr(4)),  32'h080);
    chk("f1_l1c0",  32'(wr(5)),  32'h13E);
    chk("f1_l1c1",  32'(wr(6)),  32'h13E);
    chk("f1_l1c2",  32'(wr(7)),  32'h120);
    chk("f1_l1c3",  32'(wr(8)),  32'h145);
    chk("f1_addr2", 32'(wr(21)), 32'h0C0);
    chk("f1_l2c0",  32'(wr(22)), 32'h120);
    chk("f1_l2c2",  32'(wr(24)), 32'h120);
    chk("f1_l2c3",  32'(wr(25)), 32'h144);
    chk("fd_count1", 32'(n_fd), 32'd1);

`ifdef LCD_CHANGE_ONLY_EN
    repeat (200) tick();
    chk("idle_writes", 32'(wq.size()), 32'd38);
    chk("idle_fd",     32'(n_fd),      32'd1);
    line2[7:0] = 8'h41;
    repeat (4) tick();
    chk("chg_restart", 32'(wq.size()), 32'd39);
    chk("chg_addr1",   32'(wr(38)),    32'h080);
    wait_fd(2, 400, "frame2");
    chk("chg_l2c15",   32'(wr(71)),    32'h141);
    chk("erun_len",    32'(erun_bad),  32'd0);
`else
    // frame 2: line 1 changes while char 5 is being written
    wait_writes(45, 400, "f2_char5");
    line1 = s2v("ENTER THE CODE..");
    wait_fd(3, 800, "frame3");
    chk("f2_l1c0_old", 32'(wr(39)), 32'h13E);
    chk("f2_l1c5_old", 32'(wr(44)), 32'h143);
    chk("f3_l1c0_new", 32'(wr(73)), 32'h145);
    chk("f3_l1c15_new", 32'(wr(88)), 32'h12E);

    // frame 4: unprintable bytes become spaces
    line2[127:120] = 8'h07;
    line2[119:112] = 8'h80;
    wait_fd(4, 400, "frame4");
    chk("f4_addr2",  32'(wr(123)), 32'h0C0);
    chk("f4_l2c0",   32'(wr(124)), 32'h120);
    chk("f4_l2c1",   32'(wr(125)), 32'h120);
    chk("f4_l2c3",   32'(wr(127)), 32'h144);
    chk("erun_len",  32'(erun_bad), 32'd0);

    // frame 5: reset pulse while enable is high during line 2
    wait_writes(162, 400, "f5_l2c3");
    chk("pre_rst_e",  32'(lcd_e),    32'h1);
    chk("pre_rst_w",  32'(wr(161)),  32'h144);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("post_rst_e",    32'(lcd_e),     32'h0);
    chk("post_rst_init", 32'(init_done), 32'h0);
    wait_fd(5, 400, "frame_after_rst");
    chk("rst_init_cyc", 32'(init_cyc), 32'd43);
    chk("rst_fd_cyc",   32'(fd_cyc),   32'd281);
    chk("rst_w0", 32'(wr(162)), 32'h038);
    chk("rst_w1", 32'(wr(163)), 32'h00C);
    chk("rst_w2", 32'(wr(164)), 32'h006);
    chk("rst_w3", 32'(wr(165)), 32'h001);
`endif

    repeat (3) tick();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
